// File: rtl/data_mem_ctrl.sv
// Multi-cycle word-access responder for the EX/MEM stage: owns the data RAM, freezes the pipeline
// with stall_o while an access is in flight. Optional macro MISALIGN_TRAP_EN suppresses misaligned accesses.
module data_mem_ctrl #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        done_o,
   output logic        misalign_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic [31:0]      rdata_q, rdata_d;

   logic [31:0]      mem [DEPTH];

   logic             req;
   logic             accept;
   logic             enter_done;
   logic [IDX_W-1:0] addr_idx;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      acc_wdata;
   logic             acc_wr;
   logic             acc_rd;
   logic             acc_mis;
   logic             mem_we;

   // Upper address bits deliberately wrap onto the RAM.
   logic unused_addr;
   assign unused_addr = ^addr_i[31:IDX_W+2];

   assign req      = MemRead_i | MemWrite_i;
   assign accept   = (state_q == S_IDLE) && req;
   assign addr_idx = addr_i[IDX_W+1:2];

   assign enter_done = (accept && (LATENCY == 1)) ||
                       ((state_q == S_BUSY) && (cnt_q == CNT_W'(1)));

   // With LATENCY==1 the completing edge is also the accepting edge, so take operands from the inputs.
   assign acc_idx   = (state_q == S_IDLE) ? addr_idx   : idx_q;
   assign acc_wdata = (state_q == S_IDLE) ? wdata_i    : wdata_q;
   assign acc_wr    = (state_q == S_IDLE) ? MemWrite_i : wr_q;
   assign acc_rd    = (state_q == S_IDLE) ? MemRead_i  : rd_q;

`ifdef MISALIGN_TRAP_EN
   logic mis_q, mis_d;

   assign acc_mis    = (state_q == S_IDLE) ? (|addr_i[1:0]) : mis_q;
   assign misalign_o = (state_q == S_DONE) && mis_q;

   always_comb begin
      mis_d = mis_q;
      if (accept) begin
         mis_d = |addr_i[1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end
`else
   logic unused_byte_offset;
   assign unused_byte_offset = ^addr_i[1:0];
   assign acc_mis    = 1'b0;
   assign misalign_o = 1'b0;
`endif

   assign mem_we = enter_done && acc_wr && !acc_mis;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               idx_d   = addr_idx;
               wdata_d = wdata_i;
               wr_d    = MemWrite_i;
               rd_d    = MemRead_i;
               if (LATENCY == 1) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         // Inputs still hold the completed request here; never re-issue it.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A simultaneous read+write returns the stored word.
   always_comb begin
      rdata_d = rdata_q;
      if (enter_done && !acc_mis) begin
         if (acc_wr && acc_rd) begin
            rdata_d = acc_wdata;
         end else if (acc_rd) begin
            rdata_d = mem[acc_idx];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign rdata_o = rdata_q;
   assign done_o  = (state_q == S_DONE);
   assign stall_o = rst_i && (accept || (state_q == S_BUSY));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: stimulus queues expected completions, a monitor checks each done_o.
module tb_data_mem_ctrl;

   localparam int LAT = 3;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        done_o;
   logic        misalign_o;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH(256), .LATENCY(LAT)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .MemRead_i  (MemRead_i),
      .MemWrite_i (MemWrite_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .misalign_o (misalign_o)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   txn       = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: counts stall cycles since the last completion and checks each done_o against the queue.
   initial begin
      exp_t e;
      int   stall_run;
      stall_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_i) begin
            stall_run = 0;
         end else begin
            if (stall_o) stall_run++;
            if (done_o) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  txn++;
                  $display("txn %0d: rdata=0x%08h misalign=%0b stall_cycles=%0d", txn, rdata_o, misalign_o, stall_run);
                  check("rdata", rdata_o, e.rdata);
                  check("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
                  check("stall_cycles", 32'(stall_run), 32'(LAT));
                  check("stall_in_done", {31'd0, stall_o}, 32'd0);
               end
               stall_run = 0;
            end
         end
      end
   end

   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_mis);
      bit seen;
      sb_q.push_back('{exp_rd, exp_mis});
      @(posedge clk); #1;
      MemRead_i  = rd;
      MemWrite_i = wr;
      addr_i     = a;
      wdata_i    = d;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         seen = done_o;
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         if (sb_q.size() > 0) void'(sb_q.pop_back());
      end
      MemRead_i  = 1'b0;
      MemWrite_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m_exp;
      rst_i      = 1'b0;
      MemRead_i  = 1'b1;
      MemWrite_i = 1'b0;
      addr_i     = 32'h0;
      wdata_i    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata", rdata_o, 32'h0);
      check("reset_stall", {31'd0, stall_o}, 32'd0);
      check("reset_done", {31'd0, done_o}, 32'd0);
      check("reset_misalign", {31'd0, misalign_o}, 32'd0);
      MemRead_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b1;

      do_access(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
      do_access(1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      do_access(1'b0, 1'b1, 32'h400, 32'h1,        32'hDEADBEEF, 1'b0);
      do_access(1'b1, 1'b0, 32'h0,   32'h0,        32'h1,        1'b0);
      do_access(1'b1, 1'b1, 32'h8,   32'h55,       32'h55,       1'b0);
      do_access(1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      do_access(1'b1, 1'b0, 32'h8,   32'h0,        32'h55,       1'b0);
      do_access(1'b0, 1'b1, 32'h20,  32'h1234,     32'h55,       1'b0);

      // Abort a store mid-access with reset; the request stays asserted on the inputs.
      @(posedge clk); #1;
      MemWrite_i = 1'b1;
      addr_i     = 32'h20;
      wdata_i    = 32'h77;
      @(posedge clk); #3;
      rst_i = 1'b0;
      #1;
      $display("abort: stall=%0b rdata=0x%08h done=%0b", stall_o, rdata_o, done_o);
      check("abort_stall", {31'd0, stall_o}, 32'd0);
      check("abort_rdata", rdata_o, 32'h0);
      check("abort_done", {31'd0, done_o}, 32'd0);
      check("abort_misalign", {31'd0, misalign_o}, 32'd0);
      MemWrite_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b1;

      do_access(1'b1, 1'b0, 32'h20,  32'h0,        32'h1234,     1'b0);
      do_access(1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      do_access(1'b0, 1'b1, 32'h12,  32'h99,       32'hDEADBEEF, TRAP);
      do_access(1'b1, 1'b0, 32'h10,  32'h0,        TRAP ? 32'hDEADBEEF : 32'h99, 1'b0);
      m_exp = TRAP ? (TRAP ? 32'hDEADBEEF : 32'h99) : 32'h1;
      do_access(1'b1, 1'b0, 32'h2,   32'h0,        m_exp,        TRAP);
      do_access(1'b0, 1'b1, 32'h3FC, 32'hA5A5,     m_exp,        1'b0);
      do_access(1'b1, 1'b0, 32'hFFC, 32'h0,        32'hA5A5,     1'b0);

      repeat (4) @(posedge clk);
      #1;
      check("idle_stall", {31'd0, stall_o}, 32'd0);
      check("idle_done", {31'd0, done_o}, 32'd0);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
